// File: rtl/morse_keyer_if.sv
`default_nettype none
// =============================================================================
//  Module   : morse_keyer_if
//  Brief    : Byte-write bus from the SPI device protocol block to the keyer.
//  Revision : 1.0  initial release
// =============================================================================
interface morse_keyer_if;
    logic [7:0] pw_wdata;
    logic       pw_wcmd;
    logic       pw_wstb;
    logic       pw_end;

    modport master (output pw_wdata, output pw_wcmd, output pw_wstb, output pw_end);
    modport slave  (input  pw_wdata, input  pw_wcmd, input  pw_wstb, input  pw_end);
endinterface
`default_nettype wire

// File: rtl/morse_keyer.sv
`default_nettype none
// =============================================================================
//  Module   : morse_keyer
//  Brief    : Buffers ASCII text from SPI write frames and keys it out as Morse.
//  Revision : 1.0  initial release
// =============================================================================
module morse_keyer #(
    parameter int         UNIT_CYCLES = 2160000,
    parameter int         DEPTH       = 16,
    parameter logic [7:0] CMD_TEXT    = 8'h10,
    parameter logic [7:0] CMD_ABORT   = 8'h11
) (
    input  wire logic          clk,
    input  wire logic          rst,
    morse_keyer_if.slave       pw,
    output logic               key,
    output logic               busy,
    output logic               fifo_full,
    output logic               overflow
);

    localparam int c_tw  = $clog2(5 * UNIT_CYCLES);
    localparam int c_pw  = $clog2(DEPTH);
    localparam int c_cw  = c_pw + 1;
    localparam logic [c_tw-1:0] c_load_1u = c_tw'(UNIT_CYCLES - 1);
    localparam logic [c_tw-1:0] c_load_3u = c_tw'(3 * UNIT_CYCLES - 1);
    localparam logic [c_tw-1:0] c_load_4u = c_tw'(4 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_MARK   = 3'd2,
        S_ESPACE = 3'd3,
        S_CSPACE = 3'd4,
        S_WSPACE = 3'd5
    } state_t;

    // Returns {len[2:0], pattern[4:0]}; pattern is left-aligned, 1 = dash,
    // bit 4 is the first element. len 0 marks an unsupported byte.
    function automatic logic [7:0] morse_code(input logic [7:0] ch);
        case (ch)
            "A": morse_code = {3'd2, 5'b01000};
            "B": morse_code = {3'd4, 5'b10000};
            "C": morse_code = {3'd4, 5'b10100};
            "D": morse_code = {3'd3, 5'b10000};
            "E": morse_code = {3'd1, 5'b00000};
            "F": morse_code = {3'd4, 5'b00100};
            "G": morse_code = {3'd3, 5'b11000};
            "H": morse_code = {3'd4, 5'b00000};
            "I": morse_code = {3'd2, 5'b00000};
            "J": morse_code = {3'd4, 5'b01110};
            "K": morse_code = {3'd3, 5'b10100};
            "L": morse_code = {3'd4, 5'b01000};
            "M": morse_code = {3'd2, 5'b11000};
            "N": morse_code = {3'd2, 5'b10000};
            "O": morse_code = {3'd3, 5'b11100};
            "P": morse_code = {3'd4, 5'b01100};
            "Q": morse_code = {3'd4, 5'b11010};
            "R": morse_code = {3'd3, 5'b01000};
            "S": morse_code = {3'd3, 5'b00000};
            "T": morse_code = {3'd1, 5'b10000};
            "U": morse_code = {3'd3, 5'b00100};
            "V": morse_code = {3'd4, 5'b00010};
            "W": morse_code = {3'd3, 5'b01100};
            "X": morse_code = {3'd4, 5'b10010};
            "Y": morse_code = {3'd4, 5'b10110};
            "Z": morse_code = {3'd4, 5'b11000};
            "0": morse_code = {3'd5, 5'b11111};
            "1": morse_code = {3'd5, 5'b01111};
            "2": morse_code = {3'd5, 5'b00111};
            "3": morse_code = {3'd5, 5'b00011};
            "4": morse_code = {3'd5, 5'b00001};
            "5": morse_code = {3'd5, 5'b00000};
            "6": morse_code = {3'd5, 5'b10000};
            "7": morse_code = {3'd5, 5'b11000};
            "8": morse_code = {3'd5, 5'b11100};
            "9": morse_code = {3'd5, 5'b11110};
            default: morse_code = 8'h00;
        endcase
    endfunction

    logic [7:0]      r_mem [DEPTH];
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic            r_overflow;
    logic            r_armed;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_tw-1:0] r_cnt;
    logic [c_tw-1:0] w_cnt_nxt;
    logic [2:0]      r_len;
    logic [2:0]      w_len_nxt;
    logic [4:0]      r_pat;
    logic [4:0]      w_pat_nxt;
    logic            r_key;

    logic            w_full;
    logic            w_empty;
    logic            w_cmd;
    logic            w_abort;
    logic            w_push;
    logic            w_pop;
    logic            w_write;
    logic            w_drop;
    logic [7:0]      w_head;
    logic [7:0]      w_upper;
    logic [7:0]      w_code;
    logic            w_is_space;

    assign w_full     = (r_count == c_cw'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_cmd      = pw.pw_wstb & pw.pw_wcmd;
    assign w_abort    = w_cmd & (pw.pw_wdata == CMD_ABORT);
    assign w_push     = pw.pw_wstb & ~pw.pw_wcmd & r_armed;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign w_write    = w_push & (~w_full | w_pop);
    assign w_drop     = w_push & w_full & ~w_pop;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_upper    = (w_head >= "a" && w_head <= "z") ? (w_head - 8'h20) : w_head;
    assign w_code     = morse_code(w_upper);
    assign w_is_space = (w_head == " ");

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= pw.pw_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            if (pw.pw_end) begin
                r_armed <= 1'b0;
            end else if (w_cmd) begin
                r_armed <= (pw.pw_wdata == CMD_TEXT);
            end
            if (w_abort) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + c_cw'(w_write) - c_cw'(w_pop);
                if (w_drop)  r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '0) ? (r_cnt - 1'b1) : r_cnt;
        w_len_nxt   = r_len;
        w_pat_nxt   = r_pat;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_pop = 1'b1;
                if (w_is_space) begin
                    w_state_nxt = S_WSPACE;
                    w_cnt_nxt   = c_load_4u;
                end else if (w_code[7:5] != 3'd0) begin
                    w_state_nxt = S_MARK;
                    w_len_nxt   = w_code[7:5];
                    w_pat_nxt   = w_code[4:0];
                    w_cnt_nxt   = w_code[4] ? c_load_3u : c_load_1u;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MARK: begin
                if (r_cnt == '0) begin
                    w_pat_nxt = {r_pat[3:0], 1'b0};
                    w_len_nxt = r_len - 1'b1;
                    if (r_len == 3'd1) begin
                        w_state_nxt = S_CSPACE;
                        w_cnt_nxt   = c_load_3u;
                    end else begin
                        w_state_nxt = S_ESPACE;
                        w_cnt_nxt   = c_load_1u;
                    end
                end
            end
            S_ESPACE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_MARK;
                    w_cnt_nxt   = r_pat[4] ? c_load_3u : c_load_1u;
                end
            end
            S_CSPACE, S_WSPACE: begin
                if (r_cnt == '0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // key is registered off the next state so it tracks MARK cycle-for-cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_pat   <= '0;
            r_key   <= 1'b0;
        end else if (w_abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_key   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_pat   <= w_pat_nxt;
            r_key   <= (w_state_nxt == S_MARK);
        end
    end

    assign key       = r_key;
    assign busy      = (r_state != S_IDLE) | ~w_empty;
    assign fifo_full = w_full;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_morse_keyer.sv
`default_nettype none
// =============================================================================
//  Module   : tb_morse_keyer
//  Brief    : Directed self-checking bench for morse_keyer (UNIT_CYCLES=4, DEPTH=4).
//  Revision : 1.0  initial release
// =============================================================================
module tb_morse_keyer;

    localparam logic [7:0] C_TEXT  = 8'h10;
    localparam logic [7:0] C_ABORT = 8'h11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key, busy, fifo_full, overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic tr_key  [0:127];
    logic tr_busy [0:127];
    logic tr_full [0:127];
    logic tr_ovf  [0:127];
    logic exp_key [0:127];
    int   exp_n;

    morse_keyer_if u_if ();

    morse_keyer #(
        .UNIT_CYCLES (4),
        .DEPTH       (4),
        .CMD_TEXT    (C_TEXT),
        .CMD_ABORT   (C_ABORT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .pw        (u_if),
        .key       (key),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: every call starts and ends 1 ns after a rising edge.
    task automatic strobe(input logic cmd, input logic [7:0] data);
        u_if.pw_wcmd  = cmd;
        u_if.pw_wdata = data;
        u_if.pw_wstb  = 1'b1;
        @(posedge clk); #1;
        u_if.pw_wstb  = 1'b0;
        u_if.pw_wcmd  = 1'b0;
        u_if.pw_wdata = 8'h00;
    endtask

    task automatic pulse_end();
        u_if.pw_end = 1'b1;
        @(posedge clk); #1;
        u_if.pw_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tr_key[i]  = key;
            tr_busy[i] = busy;
            tr_full[i] = fifo_full;
            tr_ovf[i]  = overflow;
        end
        @(posedge clk); #1;
    endtask

    task automatic exp_clear();
        exp_n = 0;
    endtask

    task automatic exp_seg(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            exp_key[exp_n] = v;
            exp_n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp += 4;
        if (key !== 1'b0)       begin n_bad++; $display("FAIL reset_key: got %b want 0", key); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", fifo_full); end
        if (overflow !== 1'b0)  begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_e();
        strobe(1'b1, C_TEXT);
        strobe(1'b0, "E");
        capture(24);
        exp_clear(); exp_seg(1'b0, 2); exp_seg(1'b1, 4); exp_seg(1'b0, 18);
        for (int i = 0; i < 24; i++) begin
            n_cmp++;
            if (tr_key[i] !== exp_key[i]) begin
                n_bad++; $display("FAIL single_e key[%0d]: got %b want %b", i, tr_key[i], exp_key[i]);
            end
        end
        n_cmp += 3;
        if (tr_busy[0] !== 1'b1)  begin n_bad++; $display("FAIL single_e busy_start: got %b want 1", tr_busy[0]); end
        if (tr_busy[17] !== 1'b1) begin n_bad++; $display("FAIL single_e busy_cspace: got %b want 1", tr_busy[17]); end
        if (tr_busy[18] !== 1'b0) begin n_bad++; $display("FAIL single_e busy_done: got %b want 0", tr_busy[18]); end
        pulse_end();
    endtask

    task automatic test_case_fold();
        logic [7:0] chars [0:1];
        chars[0] = "a";
        chars[1] = "A";
        exp_clear(); exp_seg(1'b0, 2); exp_seg(1'b1, 4); exp_seg(1'b0, 4);
        exp_seg(1'b1, 12); exp_seg(1'b0, 14);
        for (int c = 0; c < 2; c++) begin
            strobe(1'b1, C_TEXT);
            strobe(1'b0, chars[c]);
            capture(36);
            for (int i = 0; i < 36; i++) begin
                n_cmp++;
                if (tr_key[i] !== exp_key[i]) begin
                    n_bad++; $display("FAIL letter_%c key[%0d]: got %b want %b", chars[c], i, tr_key[i], exp_key[i]);
                end
            end
            n_cmp += 2;
            if (tr_busy[33] !== 1'b1) begin n_bad++; $display("FAIL letter_%c busy_cspace: got %b want 1", chars[c], tr_busy[33]); end
            if (tr_busy[34] !== 1'b0) begin n_bad++; $display("FAIL letter_%c busy_done: got %b want 0", chars[c], tr_busy[34]); end
            pulse_end();
        end
    endtask

    task automatic test_spacing();
        // "E E": mark, 12 CSPACE + IDLE + FETCH + 16 WSPACE + IDLE + FETCH, mark
        strobe(1'b1, C_TEXT);
        strobe(1'b0, "E");
        strobe(1'b0, " ");
        strobe(1'b0, "E");
        capture(56);
        exp_clear(); exp_seg(1'b1, 4); exp_seg(1'b0, 32); exp_seg(1'b1, 4); exp_seg(1'b0, 16);
        for (int i = 0; i < 56; i++) begin
            n_cmp++;
            if (tr_key[i] !== exp_key[i]) begin
                n_bad++; $display("FAIL word_space key[%0d]: got %b want %b", i, tr_key[i], exp_key[i]);
            end
        end
        n_cmp += 2;
        if (tr_busy[51] !== 1'b1) begin n_bad++; $display("FAIL word_space busy_cspace: got %b want 1", tr_busy[51]); end
        if (tr_busy[52] !== 1'b0) begin n_bad++; $display("FAIL word_space busy_done: got %b want 0", tr_busy[52]); end

        // "E#E": the invalid byte costs only its IDLE/FETCH pair
        strobe(1'b0, "E");
        strobe(1'b0, "#");
        strobe(1'b0, "E");
        capture(40);
        exp_clear(); exp_seg(1'b1, 4); exp_seg(1'b0, 16); exp_seg(1'b1, 4); exp_seg(1'b0, 16);
        for (int i = 0; i < 40; i++) begin
            n_cmp++;
            if (tr_key[i] !== exp_key[i]) begin
                n_bad++; $display("FAIL invalid_char key[%0d]: got %b want %b", i, tr_key[i], exp_key[i]);
            end
        end
        n_cmp += 2;
        if (tr_busy[35] !== 1'b1) begin n_bad++; $display("FAIL invalid_char busy_cspace: got %b want 1", tr_busy[35]); end
        if (tr_busy[36] !== 1'b0) begin n_bad++; $display("FAIL invalid_char busy_done: got %b want 0", tr_busy[36]); end
        pulse_end();
    endtask

    task automatic test_back_to_back();
        int marks;
        strobe(1'b1, C_TEXT);
        for (int k = 0; k < 6; k++) strobe(1'b0, "E");
        capture(110);
        marks = tr_key[0] ? 1 : 0;
        for (int i = 1; i < 110; i++) begin
            if (tr_key[i] && !tr_key[i-1]) marks++;
        end
        n_cmp += 8;
        if (tr_full[0] !== 1'b1)  begin n_bad++; $display("FAIL b2b full_after_push: got %b want 1", tr_full[0]); end
        if (tr_ovf[0] !== 1'b1)   begin n_bad++; $display("FAIL b2b overflow: got %b want 1", tr_ovf[0]); end
        if (tr_full[14] !== 1'b1) begin n_bad++; $display("FAIL b2b full_before_pop: got %b want 1", tr_full[14]); end
        if (tr_full[15] !== 1'b0) begin n_bad++; $display("FAIL b2b full_after_pop: got %b want 0", tr_full[15]); end
        if (marks != 5)           begin n_bad++; $display("FAIL b2b marks_played: got %0d want 5", marks); end
        if (tr_busy[84] !== 1'b1) begin n_bad++; $display("FAIL b2b busy_last: got %b want 1", tr_busy[84]); end
        if (tr_busy[85] !== 1'b0) begin n_bad++; $display("FAIL b2b busy_done: got %b want 0", tr_busy[85]); end
        if (tr_ovf[109] !== 1'b1) begin n_bad++; $display("FAIL b2b overflow_sticky: got %b want 1", tr_ovf[109]); end
        pulse_end();
    endtask

    task automatic test_abort();
        strobe(1'b1, C_TEXT);
        strobe(1'b0, "T");
        strobe(1'b0, "E");
        strobe(1'b0, "E");
        idle(5);
        @(negedge clk);
        n_cmp += 3;
        if (key !== 1'b1)      begin n_bad++; $display("FAIL abort pre_key: got %b want 1", key); end
        if (busy !== 1'b1)     begin n_bad++; $display("FAIL abort pre_busy: got %b want 1", busy); end
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL abort pre_ovf: got %b want 1", overflow); end
        @(posedge clk); #1;
        strobe(1'b1, C_ABORT);
        capture(20);
        n_cmp += 3;
        if (tr_busy[0] !== 1'b0) begin n_bad++; $display("FAIL abort busy: got %b want 0", tr_busy[0]); end
        if (tr_ovf[0] !== 1'b0)  begin n_bad++; $display("FAIL abort overflow: got %b want 0", tr_ovf[0]); end
        if (tr_full[0] !== 1'b0) begin n_bad++; $display("FAIL abort full: got %b want 0", tr_full[0]); end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (tr_key[i] !== 1'b0) begin
                n_bad++; $display("FAIL abort key[%0d]: got %b want 0", i, tr_key[i]);
            end
        end
        pulse_end();
    endtask

    task automatic test_ignored();
        strobe(1'b1, 8'h22);
        strobe(1'b0, "E");
        capture(20);
        n_cmp++;
        if (tr_busy[0] !== 1'b0) begin n_bad++; $display("FAIL other_cmd busy: got %b want 0", tr_busy[0]); end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (tr_key[i] !== 1'b0) begin
                n_bad++; $display("FAIL other_cmd key[%0d]: got %b want 0", i, tr_key[i]);
            end
        end
        strobe(1'b1, C_TEXT);
        pulse_end();
        strobe(1'b0, "E");
        capture(20);
        n_cmp++;
        if (tr_busy[0] !== 1'b0) begin n_bad++; $display("FAIL after_end busy: got %b want 0", tr_busy[0]); end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (tr_key[i] !== 1'b0) begin
                n_bad++; $display("FAIL after_end key[%0d]: got %b want 0", i, tr_key[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        strobe(1'b1, C_TEXT);
        for (int k = 0; k < 6; k++) strobe(1'b0, "0");
        idle(6);
        @(negedge clk);
        n_cmp += 2;
        if (key !== 1'b1)      begin n_bad++; $display("FAIL rst_mid pre_key: got %b want 1", key); end
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL rst_mid pre_ovf: got %b want 1", overflow); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp += 4;
        if (key !== 1'b0)       begin n_bad++; $display("FAIL rst_mid key: got %b want 0", key); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_mid busy: got %b want 0", busy); end
        if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL rst_mid full: got %b want 0", fifo_full); end
        if (overflow !== 1'b0)  begin n_bad++; $display("FAIL rst_mid ovf: got %b want 0", overflow); end
        @(posedge clk); #1;
        strobe(1'b0, "E");
        capture(20);
        n_cmp++;
        if (tr_busy[0] !== 1'b0) begin n_bad++; $display("FAIL rst_mid disarmed_busy: got %b want 0", tr_busy[0]); end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (tr_key[i] !== 1'b0) begin
                n_bad++; $display("FAIL rst_mid key_after[%0d]: got %b want 0", i, tr_key[i]);
            end
        end
    endtask

    initial begin
        u_if.pw_wdata = 8'h00;
        u_if.pw_wcmd  = 1'b0;
        u_if.pw_wstb  = 1'b0;
        u_if.pw_end   = 1'b0;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_single_e();
        test_case_fold();
        test_spacing();
        test_back_to_back();
        test_abort();
        test_ignored();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
